// File: rtl/taskv_sweep.sv
// Truth-table sweeper for the 4-input combinational function taskv: walks {a,b,c,d} 0..15,
// samples f at the end of each dwell window and publishes the 16-bit table. Optional golden compare: TASKV_SWEEP_CHECK_EN.
module taskv_sweep #(
    parameter int unsigned DWELL = 10
`ifdef TASKV_SWEEP_CHECK_EN
    , parameter logic [15:0] EXPECTED = 16'h0000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        f,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out
`ifdef TASKV_SWEEP_CHECK_EN
    , output logic      mismatch
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    localparam logic [7:0] RELOAD = 8'(DWELL - 1);

    state_t      state_q;
    logic [3:0]  idx_q;
    logic [7:0]  cnt_q;
    logic [15:0] result_q;
    logic [15:0] result_d;
    logic        busy_q;
    logic        done_q;
    logic [15:0] table_q;
`ifdef TASKV_SWEEP_CHECK_EN
    logic        mismatch_q;
`endif

    // Result word with the current vector's sample merged in, so the final
    // vector's bit is already present when table_out loads at FIN entry.
    always_comb begin
        result_d         = result_q;
        result_d[idx_q]  = f;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            cnt_q      <= 8'd0;
            result_q   <= 16'h0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            table_q    <= 16'h0000;
`ifdef TASKV_SWEEP_CHECK_EN
            mismatch_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    idx_q  <= 4'd0;
                    if (start) begin
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        cnt_q    <= RELOAD;
                        result_q <= 16'h0000;
                    end
                end
                RUN: begin
                    if (cnt_q == 8'd0) begin
                        result_q <= result_d;
                        if (idx_q != 4'd15) begin
                            idx_q <= idx_q + 4'd1;
                            cnt_q <= RELOAD;
                        end else begin
                            // idx returns to 0 here so the vector outputs read 0 in FIN.
                            state_q    <= FIN;
                            idx_q      <= 4'd0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            table_q    <= result_d;
`ifdef TASKV_SWEEP_CHECK_EN
                            mismatch_q <= (result_d != EXPECTED);
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= 4'd0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign {a, b, c, d} = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign table_out    = table_q;
`ifdef TASKV_SWEEP_CHECK_EN
    assign mismatch     = mismatch_q;
`endif

endmodule
